pipelined_parallel_fft: RTL
===========================

Name: pipelined_parallel_fft

Overview:
- Fully parallel radix-2 decimation-in-time FFT over 2^NPOINT complex points.
- One butterfly rank is registered per clock, so a new frame is accepted every cycle.
- valid/busy handshake on both sides; back-pressure from the downstream consumer stalls the whole pipeline.
- Next-generation full-parallel FFT core: adds per-stage scaling, stage pipelining, twiddles carried with each frame, and natural-order output.

Parameters:
- NPOINT, 3, log2 of FFT size N (N = 2^NPOINT, legal 1..6)
- WIDTH, 16, signed bit width of each real/imag sample and twiddle
- SCALE, 1, 1 = divide by 2 per stage (output = DFT/N); 0 = unscaled (output = DFT)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
- din_valid  input  1  input frame present
- din_busy  output  1  core cannot accept; equals dout_valid & dout_busy (combinational)
- din_real  input  WIDTH*N  sample k at bits [k*WIDTH +: WIDTH], natural order
- din_imag  input  WIDTH*N  as din_real
- din_weight_real  input  WIDTH*N/2  twiddle W_N^k real part, k = 0..N/2-1, Q2.(WIDTH-2)
- din_weight_imag  input  WIDTH*N/2  twiddle imag part, same format
- dout_valid  output  1  output frame present
- dout_busy  input  1  downstream cannot accept
- dout_real  output  WIDTH*N  result bin k at [k*WIDTH +: WIDTH], natural order
- dout_imag  output  WIDTH*N  as dout_real

Behaviour:
- Acceptance: a frame is accepted when din_valid=1 and din_busy=0.
- Twiddles are sampled together with the data at acceptance and travel down the pipeline with the frame, so consecutive frames may use different twiddle sets.
- Pipeline: input register (bit-reversal reorder, no arithmetic), then stage s = 1..NPOINT registers.
  - Latency is NPOINT+1 cycles from acceptance to dout_valid when there is no stall.
  - Each stage carries its own valid bit; empty slots (bubbles) propagate.
- Stall: while dout_valid=1 and dout_busy=1, every stage register and every valid bit holds its value.
  - Otherwise all stages advance; bubbles are overwritten.
  - dout holds stable while stalled.
- A frame is consumed when dout_valid=1 and dout_busy=0.
- Butterfly at stage s, group size m = 2^s, pair (a, b) with b offset m/2:
  - twiddle index j*2^(NPOINT-s), j = position within the half-group
  - t = b*W, with a full 2*WIDTH-bit complex product per component
  - t is rounded by adding 2^(WIDTH-3) and arithmetic-shifting right by WIDTH-2, giving WIDTH+1 bits
  - outputs a+t and a-t are computed in WIDTH+2 bits
- Width reduction:
  - SCALE=1: add 1, arithmetic-shift right 1, keep the low WIDTH bits.
  - SCALE=0: keep the low WIDTH bits (two's-complement wrap).
- Reset (rst_n=1 at a clock edge):
  - all valid bits clear; dout_valid=0, dout_real=0, dout_imag=0, all stage data registers 0
  - din_busy therefore reads 0
  - frames in flight are discarded
  - reset has priority over stall.
- Simultaneous consume and accept in one cycle is legal; full throughput is one frame per clock.

Optional Feature:
- Macro: FFT_SATURATE_EN.
- Defined:
  - Width reduction saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1] instead of wrapping.
  - Extra port ovf output 1: a sticky flag set when any stage saturates a frame that is valid; cleared only by reset.
- Undefined: wrap behaviour; no ovf port.

Test Plan (NPOINT=3, WIDTH=16, twiddles real {16384,11585,0,-11585}, imag {0,-11585,-16384,-11585}):
- Impulse, din_real[0]=1000, all others 0, SCALE=1 -> all 8 bins real=125, imag=0; dout_valid rises exactly 4 cycles after acceptance.
- DC, all din_real=1000, SCALE=0 -> bin0 real=8000, bins 1..7 = 0 (±1 LSB rounding).
- Back-to-back frames (impulse, DC, impulse) with dout_busy=0 -> three consecutive dout_valid cycles in order; din_busy stays 0.
- Stall: dout_busy=1 while dout_valid=1 for 5 cycles -> din_busy=1, dout frozen, no frame lost or duplicated after release.
- rst_n pulsed with 2 frames in flight -> next cycle dout_valid=0, dout=0; no stale frame emerges later.
- All din_real=32767, SCALE=0 -> with FFT_SATURATE_EN: bin0 real=32767, ovf=1; without: bin0 wraps to -8.

Source files
------------

// File: rtl/pipelined_parallel_fft.sv
`default_nettype none
//==============================================================================
// Module : pipelined_parallel_fft
// Brief  : Fully parallel radix-2 DIT FFT, one butterfly rank per clock, with
//          twiddles carried alongside each frame and natural-order output.
//          Define FFT_SATURATE_EN for saturating width reduction + sticky ovf.
// Rev    : 1.0  initial release
//==============================================================================
module pipelined_parallel_fft #(
    parameter int  NPOINT = 3,
    parameter int  WIDTH  = 16,
    parameter int  SCALE  = 1,
    localparam int N      = 2 ** NPOINT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din_valid,
    output logic                 din_busy,
    input  logic [WIDTH*N-1:0]   din_real,
    input  logic [WIDTH*N-1:0]   din_imag,
    input  logic [WIDTH*N/2-1:0] din_weight_real,
    input  logic [WIDTH*N/2-1:0] din_weight_imag,
    output logic                 dout_valid,
    input  logic                 dout_busy,
    output logic [WIDTH*N-1:0]   dout_real,
    output logic [WIDTH*N-1:0]   dout_imag
`ifdef FFT_SATURATE_EN
    ,
    output logic                 ovf
`endif
);

    localparam logic signed [2*WIDTH-1:0] C_RND = (2*WIDTH)'(1) <<< (WIDTH - 3);

    function automatic int bit_rev(input int k);
        int r;
        r = 0;
        for (int i = 0; i < NPOINT; i++) r = (r << 1) | ((k >> i) & 1);
        return r;
    endfunction

    function automatic logic signed [WIDTH+1:0] pre_reduce(input logic signed [WIDTH+1:0] x);
        return (SCALE != 0) ? ((x + (WIDTH+2)'(1)) >>> 1) : x;
    endfunction

`ifdef FFT_SATURATE_EN
    localparam logic signed [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic is_sat(input logic signed [WIDTH+1:0] x);
        logic signed [WIDTH+1:0] y;
        y = pre_reduce(x);
        return (y[WIDTH+1:WIDTH-1] != 3'b000) && (y[WIDTH+1:WIDTH-1] != 3'b111);
    endfunction
`endif

    function automatic logic signed [WIDTH-1:0] reduce(input logic signed [WIDTH+1:0] x);
        logic signed [WIDTH+1:0] y;
        y = pre_reduce(x);
`ifdef FFT_SATURATE_EN
        if (is_sat(x)) return y[WIDTH+1] ? C_MIN : C_MAX;
`endif
        return WIDTH'(y);
    endfunction

    // Stage 0 is the bit-reversed input register; stage NPOINT drives dout.
    logic [NPOINT:0]         r_vld;
    logic signed [WIDTH-1:0] r_re     [0:NPOINT][0:N-1];
    logic signed [WIDTH-1:0] r_im     [0:NPOINT][0:N-1];
    logic signed [WIDTH-1:0] r_wr     [0:NPOINT-1][0:N/2-1];
    logic signed [WIDTH-1:0] r_wi     [0:NPOINT-1][0:N/2-1];
    logic signed [WIDTH-1:0] w_nxt_re [0:NPOINT][0:N-1];
    logic signed [WIDTH-1:0] w_nxt_im [0:NPOINT][0:N-1];
    logic signed [WIDTH-1:0] w_din_wr [0:N/2-1];
    logic signed [WIDTH-1:0] w_din_wi [0:N/2-1];
    logic                    w_adv;

    assign dout_valid = r_vld[NPOINT];
    assign din_busy   = dout_valid & dout_busy;
    assign w_adv      = ~din_busy;

    for (genvar k = 0; k < N; k++) begin : g_io
        localparam int RK = bit_rev(k);
        assign w_nxt_re[0][k]              = din_real[RK*WIDTH +: WIDTH];
        assign w_nxt_im[0][k]              = din_imag[RK*WIDTH +: WIDTH];
        assign dout_real[k*WIDTH +: WIDTH] = r_re[NPOINT][k];
        assign dout_imag[k*WIDTH +: WIDTH] = r_im[NPOINT][k];
    end

    for (genvar k = 0; k < N/2; k++) begin : g_tw
        assign w_din_wr[k] = din_weight_real[k*WIDTH +: WIDTH];
        assign w_din_wi[k] = din_weight_imag[k*WIDTH +: WIDTH];
    end

`ifdef FFT_SATURATE_EN
    logic [3:0] w_sat [1:NPOINT][0:N/2-1];
`endif

    for (genvar s = 1; s <= NPOINT; s++) begin : g_stage
        localparam int HALF = 2 ** (s - 1);
        for (genvar k = 0; k < N/2; k++) begin : g_bf
            localparam int IA = (k / HALF) * 2 * HALF + (k % HALF);
            localparam int IB = IA + HALF;
            localparam int IW = (k % HALF) * (2 ** (NPOINT - s));
            logic signed [2*WIDTH-1:0] w_pr, w_pi;
            logic signed [WIDTH:0]     w_tr, w_ti;
            logic signed [WIDTH+1:0]   w_sr, w_si, w_dr, w_di;

            assign w_pr = (2*WIDTH)'(r_re[s-1][IB]) * (2*WIDTH)'(r_wr[s-1][IW])
                        - (2*WIDTH)'(r_im[s-1][IB]) * (2*WIDTH)'(r_wi[s-1][IW]);
            assign w_pi = (2*WIDTH)'(r_re[s-1][IB]) * (2*WIDTH)'(r_wi[s-1][IW])
                        + (2*WIDTH)'(r_im[s-1][IB]) * (2*WIDTH)'(r_wr[s-1][IW]);
            // Round-half-up back to sample scale (twiddles are Q2.(WIDTH-2)).
            assign w_tr = (WIDTH+1)'((w_pr + C_RND) >>> (WIDTH - 2));
            assign w_ti = (WIDTH+1)'((w_pi + C_RND) >>> (WIDTH - 2));
            assign w_sr = (WIDTH+2)'(r_re[s-1][IA]) + (WIDTH+2)'(w_tr);
            assign w_si = (WIDTH+2)'(r_im[s-1][IA]) + (WIDTH+2)'(w_ti);
            assign w_dr = (WIDTH+2)'(r_re[s-1][IA]) - (WIDTH+2)'(w_tr);
            assign w_di = (WIDTH+2)'(r_im[s-1][IA]) - (WIDTH+2)'(w_ti);

            assign w_nxt_re[s][IA] = reduce(w_sr);
            assign w_nxt_im[s][IA] = reduce(w_si);
            assign w_nxt_re[s][IB] = reduce(w_dr);
            assign w_nxt_im[s][IB] = reduce(w_di);
`ifdef FFT_SATURATE_EN
            assign w_sat[s][k] = {is_sat(w_sr), is_sat(w_si), is_sat(w_dr), is_sat(w_di)};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_vld <= '0;
            for (int s = 0; s <= NPOINT; s++) begin
                for (int k = 0; k < N; k++) begin
                    r_re[s][k] <= '0;
                    r_im[s][k] <= '0;
                end
            end
            for (int s = 0; s < NPOINT; s++) begin
                for (int k = 0; k < N/2; k++) begin
                    r_wr[s][k] <= '0;
                    r_wi[s][k] <= '0;
                end
            end
        end else if (w_adv) begin
            r_vld <= {r_vld[NPOINT-1:0], din_valid};
            for (int s = 0; s <= NPOINT; s++) begin
                for (int k = 0; k < N; k++) begin
                    r_re[s][k] <= w_nxt_re[s][k];
                    r_im[s][k] <= w_nxt_im[s][k];
                end
            end
            for (int k = 0; k < N/2; k++) begin
                r_wr[0][k] <= w_din_wr[k];
                r_wi[0][k] <= w_din_wi[k];
                for (int s = 1; s < NPOINT; s++) begin
                    r_wr[s][k] <= r_wr[s-1][k];
                    r_wi[s][k] <= r_wi[s-1][k];
                end
            end
        end
    end

`ifdef FFT_SATURATE_EN
    logic w_ovf_hit;
    logic r_ovf;

    always_comb begin
        w_ovf_hit = 1'b0;
        for (int s = 1; s <= NPOINT; s++) begin
            for (int k = 0; k < N/2; k++) begin
                if (r_vld[s-1] && (|w_sat[s][k])) w_ovf_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n)                       r_ovf <= 1'b0;
        else if (w_adv && w_ovf_hit)     r_ovf <= 1'b1;
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire
